// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game PS/2 input stage.
// Build option: define SNAKE_WASD_EN to also map the non-extended A/D/S/W codes.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_UP    = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DATA   = 2'b01,
    ST_PARITY = 2'b10,
    ST_STOP   = 2'b11
  } rx_state_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_W     = 8'h1D;

  typedef struct packed {
    logic hit;
    dir_e dir;
  } key_map_t;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Arrow keys arrive behind the E0 prefix; WASD (optional) arrives without it.
  function automatic key_map_t map_key(input logic [7:0] code, input logic ext);
    key_map_t m;
    m.hit = 1'b0;
    m.dir = DIR_LEFT;
    if (ext) begin
      case (code)
        SC_LEFT:  begin m.hit = 1'b1; m.dir = DIR_LEFT;  end
        SC_RIGHT: begin m.hit = 1'b1; m.dir = DIR_RIGHT; end
        SC_DOWN:  begin m.hit = 1'b1; m.dir = DIR_DOWN;  end
        SC_UP:    begin m.hit = 1'b1; m.dir = DIR_UP;    end
        default:  m.hit = 1'b0;
      endcase
    end else begin
`ifdef SNAKE_WASD_EN
      case (code)
        SC_A:    begin m.hit = 1'b1; m.dir = DIR_LEFT;  end
        SC_D:    begin m.hit = 1'b1; m.dir = DIR_RIGHT; end
        SC_S:    begin m.hit = 1'b1; m.dir = DIR_DOWN;  end
        SC_W:    begin m.hit = 1'b1; m.dir = DIR_UP;    end
        default: m.hit = 1'b0;
      endcase
`else
      m.hit = 1'b0;
`endif
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronisers, ps2_clk glitch filter, frame FSM
// with odd-parity/stop checking and a mid-frame inactivity timeout.
module ps2_rx
  import snake_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic       tmo_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic                  clk_meta_r, clk_sync_r, dat_meta_r, dat_sync_r;
  logic [FILTER_LEN-1:0] filt_sh_r;
  logic [FILTER_LEN-1:0] filt_next_s;
  logic                  filt_r, fall_r;
  rx_state_e             state_r;
  logic [2:0]            bit_cnt_r;
  logic [7:0]            shift_r;
  logic                  par_r;
  logic [TW-1:0]         tmo_r;
  logic [7:0]            scan_code_r;
  logic                  scan_valid_r, frame_err_r, tmo_err_r;

  // Two-flop synchronisers; both lines idle high.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_r <= 1'b1;
      clk_sync_r <= 1'b1;
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= ps2_clk;
      clk_sync_r <= clk_meta_r;
      dat_meta_r <= ps2_dat;
      dat_sync_r <= dat_meta_r;
    end
  end

  assign filt_next_s = {filt_sh_r[FILTER_LEN-2:0], clk_sync_r};

  // Filtered clock flips only on a full window of agreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_sh_r <= '1;
      filt_r    <= 1'b1;
      fall_r    <= 1'b0;
    end else begin
      filt_sh_r <= filt_next_s;
      fall_r    <= 1'b0;
      if (filt_next_s == '0) begin
        filt_r <= 1'b0;
        fall_r <= filt_r;
      end else if (filt_next_s == '1) begin
        filt_r <= 1'b1;
      end else begin
        filt_r <= filt_r;
      end
    end
  end

  // Frame FSM; the timeout counter restarts on every strobe and runs mid-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'h00;
      par_r        <= 1'b0;
      tmo_r        <= '0;
      scan_code_r  <= 8'h00;
      scan_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      tmo_err_r    <= 1'b0;
    end else begin
      scan_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      tmo_err_r    <= 1'b0;
      if (fall_r) begin
        tmo_r <= '0;
        case (state_r)
          ST_IDLE: begin
            if (!dat_sync_r) begin
              state_r   <= ST_DATA;
              bit_cnt_r <= 3'd0;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_DATA: begin
            shift_r   <= {dat_sync_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end else begin
              state_r <= ST_DATA;
            end
          end
          ST_PARITY: begin
            par_r   <= dat_sync_r;
            state_r <= ST_STOP;
          end
          ST_STOP: begin
            if (dat_sync_r && odd_parity_ok(shift_r, par_r)) begin
              scan_code_r  <= shift_r;
              scan_valid_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
            end
            state_r <= ST_IDLE;
          end
          default: state_r <= ST_IDLE;
        endcase
      end else if (state_r != ST_IDLE) begin
        if (tmo_r == TW'(TIMEOUT_CYCLES - 1)) begin
          state_r     <= ST_IDLE;
          tmo_r       <= '0;
          frame_err_r <= 1'b1;
          tmo_err_r   <= 1'b1;
        end else begin
          tmo_r <= tmo_r + TW'(1);
        end
      end else begin
        tmo_r <= '0;
      end
    end
  end

  assign scan_code  = scan_code_r;
  assign scan_valid = scan_valid_r;
  assign frame_err  = frame_err_r;
  assign tmo_err    = tmo_err_r;

endmodule

// File: rtl/ps2_arrow_decoder.sv
// PS/2 arrow-key decoder: tracks E0/F0 prefixes and holds one bit per direction.
// Build option: SNAKE_WASD_EN adds the A/D/S/W keys to the direction map.
module ps2_arrow_decoder
  import snake_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       mv_left,
  output logic       mv_right,
  output logic       mv_down,
  output logic       mv_up,
  output logic       key_press,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  logic [7:0] rx_code_s;
  logic       rx_valid_s, rx_err_s, rx_tmo_s;
  logic       ext_r, brk_r, key_press_r;
  logic [3:0] held_r;
  key_map_t   km_s;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .scan_code (rx_code_s),
    .scan_valid(rx_valid_s),
    .frame_err (rx_err_s),
    .tmo_err   (rx_tmo_s)
  );

  assign km_s = map_key(rx_code_s, ext_r);

  // Prefix tracking and held-key update, one cycle after each received byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_r       <= 1'b0;
      brk_r       <= 1'b0;
      key_press_r <= 1'b0;
      held_r      <= 4'b0000;
    end else begin
      key_press_r <= 1'b0;
      if (rx_valid_s) begin
        case (rx_code_s)
          SC_EXT: ext_r <= 1'b1;
          SC_BRK: brk_r <= 1'b1;
          default: begin
            ext_r       <= 1'b0;
            brk_r       <= 1'b0;
            key_press_r <= ~brk_r;
            if (km_s.hit) begin
              held_r[km_s.dir] <= ~brk_r;
            end else begin
              held_r <= held_r;
            end
          end
        endcase
      end else if (rx_tmo_s) begin
        ext_r <= 1'b0;
        brk_r <= 1'b0;
      end else begin
        ext_r <= ext_r;
        brk_r <= brk_r;
      end
    end
  end

  assign mv_left    = held_r[DIR_LEFT];
  assign mv_right   = held_r[DIR_RIGHT];
  assign mv_down    = held_r[DIR_DOWN];
  assign mv_up      = held_r[DIR_UP];
  assign key_press  = key_press_r;
  assign scan_code  = rx_code_s;
  assign scan_valid = rx_valid_s;
  assign frame_err  = rx_err_s;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Scoreboard bench for ps2_arrow_decoder: PS/2 frames are bit-banged, expected
// bytes and post-decode key state are queued at send time and checked on scan_valid.
`timescale 1ns/1ps
module tb_ps2_arrow_decoder;

  localparam int F    = 8;
  localparam int T    = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       mv_left, mv_right, mv_down, mv_up, key_press, scan_valid, frame_err;
  logic [7:0] scan_code;

  ps2_arrow_decoder #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .mv_left(mv_left), .mv_right(mv_right), .mv_down(mv_down), .mv_up(mv_up),
    .key_press(key_press), .scan_code(scan_code), .scan_valid(scan_valid),
    .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic [3:0] mv;
    logic       kp;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  int         ferr_cnt = 0;
  exp_t       exp_q[$];
  exp_t       pend;
  bit         pend_vld = 1'b0;
  logic       m_ext = 1'b0, m_brk = 1'b0;
  logic [3:0] m_held = 4'b0000;

  wire [3:0] mv = {mv_up, mv_down, mv_right, mv_left};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
    end
  endtask

  // Bench's own key map: index 0 left, 1 right, 2 down, 3 up, -1 unmapped.
  function automatic int bmap(input logic [7:0] c, input logic ext);
    if (ext) begin
      case (c)
        8'h6B: return 0;
        8'h74: return 1;
        8'h72: return 2;
        8'h75: return 3;
        default: return -1;
      endcase
    end
`ifdef SNAKE_WASD_EN
    case (c)
      8'h1C: return 0;
      8'h23: return 1;
      8'h1B: return 2;
      8'h1D: return 3;
      default: return -1;
    endcase
`else
    return -1;
`endif
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (pend_vld) begin
      check_eq("mv_after_byte", mv, pend.mv);
      check_eq("key_press", key_press, pend.kp);
      pend_vld = 1'b0;
    end else if (key_press) begin
      check_eq("key_press_spurious", key_press, 1'b0);
    end
    if (scan_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("scan_valid_unexpected", scan_valid, 1'b0);
      end else begin
        pend = exp_q.pop_front();
        check_eq("scan_code", scan_code, pend.code);
        pend_vld = 1'b1;
      end
    end
  end

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good);
    logic p;
    p = good ? ~^b : ^b;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_t e;
    int   idx;
    e.kp = 1'b0;
    if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      idx = bmap(b, m_ext);
      if (idx >= 0) m_held[idx] = !m_brk;
      e.kp  = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    e.code = b;
    e.mv   = m_held;
    exp_q.push_back(e);
    send_frame(b, 1'b1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int     ferr0;
    int     n;
    logic [7:0] pb;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_mv", mv, 4'b0000);
    check_eq("rst_key_press", key_press, 1'b0);
    check_eq("rst_scan_code", scan_code, 8'h00);
    check_eq("rst_scan_valid", scan_valid, 1'b0);
    check_eq("rst_frame_err", frame_err, 1'b0);

    // Up arrow make, then extended break.
    send_good(8'hE0); send_good(8'h75);
    check_eq("up_held", mv_up, 1'b1);
    send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
    check_eq("up_released", mv_up, 1'b0);

    // Non-extended 0x1C: left only when WASD mapping is built in.
    send_good(8'h1C);
`ifdef SNAKE_WASD_EN
    check_eq("wasd_a_left", mv_left, 1'b1);
`else
    check_eq("wasd_a_left", mv_left, 1'b0);
`endif
    send_good(8'hF0); send_good(8'h1C);
    check_eq("wasd_a_release", mv, 4'b0000);

    // Parity error: no scan_valid, no key change.
    ferr0 = ferr_cnt;
    send_frame(8'h6B, 1'b0);
    check_eq("parity_err_count", ferr_cnt - ferr0, 1);
    check_eq("parity_err_mv", mv, 4'b0000);
    send_good(8'hE0); send_good(8'h6B);
    check_eq("left_held", mv_left, 1'b1);

    // Timeout: start + 4 data bits then ps2_clk left high.
    ferr0 = ferr_cnt;
    pb = 8'h5A;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(pb[i]);
    ps2_dat = pb[3];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    n = 0;
    while (!frame_err && n < T + F + 50) begin
      @(negedge clk);
      n++;
      if (n == HALF) ps2_clk = 1'b1;
    end
    // Front end adds 2 sync + F filter + 1 strobe register before the strobe is consumed.
    check_eq("timeout_latency", n, T + F + 3);
    ps2_dat = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("timeout_err_count", ferr_cnt - ferr0, 1);
    m_ext = 1'b0; m_brk = 1'b0;
    send_good(8'hE0); send_good(8'h74);
    check_eq("right_held", mv_right, 1'b1);

    // Short glitch is filtered; a long low pulse with data 0 starts a frame.
    ferr0 = ferr_cnt;
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (T + 50) @(negedge clk);
    check_eq("glitch_no_frame", ferr_cnt - ferr0, 0);
    ps2_clk = 1'b0;
    repeat (F + 2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (T + 50) @(negedge clk);
    check_eq("pulse_starts_frame", ferr_cnt - ferr0, 1);
    ps2_dat = 1'b1;
    m_ext = 1'b0; m_brk = 1'b0;
    repeat (10) @(negedge clk);

    // Several held keys, then reset in the middle of a frame.
    send_good(8'hE0); send_good(8'h6B);
    send_good(8'hE0); send_good(8'h72);
    check_eq("multi_held", mv, m_held);
    check_eq("left_down_both", {mv_down, mv_left}, 2'b11);
    ferr0 = ferr_cnt;
    pb = 8'h75;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(pb[i]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst_mv", mv, 4'b0000);
    check_eq("midrst_scan_code", scan_code, 8'h00);
    check_eq("midrst_key_press", key_press, 1'b0);
    m_ext = 1'b0; m_brk = 1'b0; m_held = 4'b0000;
    ps2_dat = 1'b1;
    repeat (T + 50) @(negedge clk);
    check_eq("midrst_no_err", ferr_cnt - ferr0, 0);
    send_good(8'hE0); send_good(8'h75);
    check_eq("post_rst_up", mv, 4'b1000);

    repeat (20) @(negedge clk);
    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
